display_scan_ctrl: RTL and testbench

// - Time-multiplexes NUM_DIGITS seven-segment digits that share one display_decoder.
// - Holds a frame buffer of nibble/letter-flag pairs and drives the decoder inputs (digit_o, ltr_o).
// - Drives the active-low common anodes (an_o) with a blanking guard to avoid ghosting.
// - Tear-free host updates: new data is staged and committed only at a frame boundary.

---
 rtl/display_scan_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexes NUM_DIGITS seven-segment digits that share one decoder.
// A frame buffer of nibble/letter-flag pairs is scanned one digit slot at a
// time. Each slot starts with BLANK_CYC cycles of all anodes off so the
// decoder inputs can settle without ghosting onto the previous digit. Host
// writes are staged and only committed at a frame boundary, so a frame is
// never drawn half old / half new.
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//   when defined, leading zero digits (nibble 0, letter flag 0) are replaced
//   by blank (4'hF) at commit time, scanning down from the top digit and
//   stopping at the first other digit. Digit 0 is never blanked. When
//   undefined, nibbles are committed unmodified.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   enable_i   1 = scan, 0 = display dark (scan held at digit 0, cnt 0)
//   wr_en_i    1-cycle write strobe
//   wr_data_i  nibble per digit, digit k = [4k+3:4k], digit 0 = rightmost
//   wr_ltr_i   letter-mode flag per digit
//   digit_o    nibble to decoder
//   ltr_o      letter flag to decoder
//   an_o       anode enables, active-low, at most one low
//   frame_o    1-cycle pulse after each frame boundary
//   pending_o  staged write not yet committed
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int DIGIT_CYC  = 100000,
    parameter int BLANK_CYC  = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_i,
    input  logic                    wr_en_i,
    input  logic [4*NUM_DIGITS-1:0] wr_data_i,
    input  logic [NUM_DIGITS-1:0]   wr_ltr_i,
    output logic [3:0]              digit_o,
    output logic                    ltr_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o,
    output logic                    pending_o
);

    localparam int CW = $clog2(DIGIT_CYC);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYC - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [3:0]              digit_q, digit_d;
    logic                    ltr_q, ltr_d;
    logic                    frame_q, frame_d;
    logic                    pending_q, pending_d;

    logic [3:0]              fb_nib_q  [NUM_DIGITS];
    logic [3:0]              fb_nib_d  [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   fb_ltr_q, fb_ltr_d;
    logic [3:0]              stg_nib_q [NUM_DIGITS];
    logic [3:0]              stg_nib_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   stg_ltr_q, stg_ltr_d;

    logic [3:0]              wr_nib    [NUM_DIGITS];
    logic [3:0]              src_nib   [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   src_ltr;
    logic [3:0]              cmt_nib   [NUM_DIGITS];

    logic                    last_slot;
    logic                    boundary;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
            assign wr_nib[gi] = wr_data_i[4*gi +: 4];
        end
    endgenerate

    // Data to commit: a write on the boundary cycle bypasses staging.
    always_comb begin
        src_ltr = wr_en_i ? wr_ltr_i : stg_ltr_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            src_nib[k] = wr_en_i ? wr_nib[k] : stg_nib_q[k];
            cmt_nib[k] = src_nib[k];
        end
`ifdef LEADING_ZERO_BLANK_EN
        begin : lz_blank
            logic leading;
            leading = 1'b1;
            for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
                if (leading && (src_nib[k] == 4'h0) && !src_ltr[k]) begin
                    cmt_nib[k] = 4'hF;
                end else begin
                    leading = 1'b0;
                end
            end
        end
`endif
    end

    always_comb begin
        last_slot = (cnt_q == CNT_LAST);
        boundary  = enable_i && last_slot && (idx_q == IDX_LAST);

        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!enable_i) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (last_slot) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        // Anodes are computed from the next count so they line up with cnt_q.
        an_d = '1;
        if (enable_i && (cnt_d >= CNT_BLANK)) begin
            an_d[idx_d] = 1'b0;
        end

        // Decoder inputs load at slot start, settling while anodes are off.
        digit_d = digit_q;
        ltr_d   = ltr_q;
        if (cnt_q == '0) begin
            digit_d = fb_nib_q[idx_q];
            ltr_d   = fb_ltr_q[idx_q];
        end

        frame_d = boundary;

        fb_nib_d  = fb_nib_q;
        fb_ltr_d  = fb_ltr_q;
        stg_nib_d = stg_nib_q;
        stg_ltr_d = stg_ltr_q;
        pending_d = pending_q;
        if (boundary && wr_en_i) begin
            fb_nib_d  = cmt_nib;
            fb_ltr_d  = src_ltr;
            pending_d = 1'b0;
        end else if (wr_en_i) begin
            stg_nib_d = wr_nib;
            stg_ltr_d = wr_ltr_i;
            pending_d = 1'b1;
        end else if ((boundary || !enable_i) && pending_q) begin
            // While dark there is no frame to tear, so commit right away.
            fb_nib_d  = cmt_nib;
            fb_ltr_d  = src_ltr;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            an_q      <= '1;
            digit_q   <= 4'hF;
            ltr_q     <= 1'b0;
            frame_q   <= 1'b0;
            pending_q <= 1'b0;
            fb_ltr_q  <= '0;
            stg_ltr_q <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                fb_nib_q[k]  <= 4'hF;
                stg_nib_q[k] <= 4'hF;
            end
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            digit_q   <= digit_d;
            ltr_q     <= ltr_d;
            frame_q   <= frame_d;
            pending_q <= pending_d;
            fb_nib_q  <= fb_nib_d;
            fb_ltr_q  <= fb_ltr_d;
            stg_nib_q <= stg_nib_d;
            stg_ltr_q <= stg_ltr_d;
        end
    end

    assign an_o      = an_q;
    assign digit_o   = digit_q;
    assign ltr_o     = ltr_q;
    assign frame_o   = frame_q;
    assign pending_o = pending_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Randomized bench for display_scan_ctrl (4 digits, 10-cycle slots, 2-cycle
// blanking). The reference model tracks time within a frame as a single
// integer t and derives the slot, digit and anode pattern arithmetically;
// the frame buffer, staging register and pending flag follow the commit rules.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

    localparam int N  = 4;
    localparam int DC = 10;
    localparam int B  = 2;
    localparam int FRAME = N * DC;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable_i;
    logic          wr_en_i;
    logic [15:0]   wr_data_i;
    logic [3:0]    wr_ltr_i;
    logic [3:0]    digit_o;
    logic          ltr_o;
    logic [3:0]    an_o;
    logic          frame_o;
    logic          pending_o;

    display_scan_ctrl #(.NUM_DIGITS(N), .DIGIT_CYC(DC), .BLANK_CYC(B)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable_i  (enable_i),
        .wr_en_i   (wr_en_i),
        .wr_data_i (wr_data_i),
        .wr_ltr_i  (wr_ltr_i),
        .digit_o   (digit_o),
        .ltr_o     (ltr_o),
        .an_o      (an_o),
        .frame_o   (frame_o),
        .pending_o (pending_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model state
    int          t;
    logic [15:0] m_fb;
    logic [3:0]  m_fbl;
    logic [15:0] m_stg;
    logic [3:0]  m_stgl;
    logic        m_pend;
    logic [3:0]  m_sd;
    logic        m_sl;
    logic        m_fr;

    function automatic logic [15:0] lzb(input logic [15:0] d, input logic [3:0] l);
        logic [15:0] r;
        r = d;
`ifdef LEADING_ZERO_BLANK_EN
        for (int k = N - 1; k >= 1; k--) begin
            if (d[4*k +: 4] != 4'h0 || l[k]) break;
            r[4*k +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    task automatic model_reset();
        t      = 0;
        m_fb   = 16'hFFFF;
        m_fbl  = 4'h0;
        m_stg  = 16'hFFFF;
        m_stgl = 4'h0;
        m_pend = 1'b0;
        m_sd   = 4'hF;
        m_sl   = 1'b0;
        m_fr   = 1'b0;
    endtask

    // Apply one clock edge to the model, using the inputs driven before it.
    task automatic model_step();
        int  cnt;
        int  idx;
        bit  bnd;
        cnt = t % DC;
        idx = t / DC;
        bnd = enable_i && (t == FRAME - 1);
        if (cnt == 0) begin
            m_sd = m_fb[4*idx +: 4];
            m_sl = m_fbl[idx];
        end
        m_fr = bnd;
        if (bnd && wr_en_i) begin
            m_fb   = lzb(wr_data_i, wr_ltr_i);
            m_fbl  = wr_ltr_i;
            m_pend = 1'b0;
        end else if (wr_en_i) begin
            m_stg  = wr_data_i;
            m_stgl = wr_ltr_i;
            m_pend = 1'b1;
        end else if ((bnd || !enable_i) && m_pend) begin
            m_fb   = lzb(m_stg, m_stgl);
            m_fbl  = m_stgl;
            m_pend = 1'b0;
        end
        t = enable_i ? (t + 1) % FRAME : 0;
    endtask

    task automatic check_outputs();
        logic [3:0] an_exp;
        an_exp = 4'hF;
        if ((t % DC) >= B) an_exp[t / DC] = 1'b0;
        check("an_o",      an_o,      an_exp);
        check("digit_o",   digit_o,   m_sd);
        check("ltr_o",     ltr_o,     m_sl);
        check("frame_o",   frame_o,   m_fr);
        check("pending_o", pending_o, m_pend);
    endtask

    logic [15:0] pat_data [4];
    logic [3:0]  pat_ltr  [4];

    initial begin
        int dis_left;
        bit boundary_now;
        int pick;

        pat_data[0] = 16'h1234; pat_ltr[0] = 4'b0000;
        pat_data[1] = 16'h5A00; pat_ltr[1] = 4'b1100;
        pat_data[2] = 16'h0070; pat_ltr[2] = 4'b0000;
        pat_data[3] = 16'h0000; pat_ltr[3] = 4'b0000;

        rst       = 1'b1;
        enable_i  = 1'b0;
        wr_en_i   = 1'b0;
        wr_data_i = '0;
        wr_ltr_i  = '0;
        dis_left  = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            check_outputs();

            if (cyc == 1500) begin
                // Asynchronous reset in the middle of a slot.
                $display("RST async at %0t", $time);
                wr_en_i = 1'b0;
                rst     = 1'b1;
                #1;
                model_reset();
                check("rst_an_o",      an_o,      4'hF);
                check("rst_digit_o",   digit_o,   4'hF);
                check("rst_pending_o", pending_o, 1'b0);
                check("rst_frame_o",   frame_o,   1'b0);
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                continue;
            end

            if (dis_left > 0) begin
                enable_i = 1'b0;
                dis_left--;
            end else begin
                if (!enable_i) $display("EN 1 at %0t", $time);
                enable_i = 1'b1;
                if ($urandom_range(0, 199) == 0) begin
                    dis_left = $urandom_range(1, 20);
                    $display("EN 0 for %0d cycles from %0t", dis_left + 1, $time);
                    enable_i = 1'b0;
                end
            end

            boundary_now = enable_i && (t == FRAME - 1);
            wr_en_i = 1'b0;
            if (enable_i && cyc > 60) begin
                if (boundary_now) wr_en_i = ($urandom_range(0, 1) == 1);
                else              wr_en_i = ($urandom_range(0, 39) == 0);
            end
            if (wr_en_i) begin
                pick = $urandom_range(0, 7);
                if (pick < 4) begin
                    wr_data_i = pat_data[pick];
                    wr_ltr_i  = pat_ltr[pick];
                end else begin
                    wr_data_i = 16'($urandom);
                    wr_ltr_i  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                end
                $display("WR data=%h ltr=%b boundary=%0d at %0t",
                         wr_data_i, wr_ltr_i, boundary_now, $time);
            end

            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
